// File: rtl/multi_byte_tx_seq.sv
// Multi-byte sequencer feeding a single-byte UART transmitter over a send_en/tx_done handshake.
// Adds per-transfer length, selectable byte order, inter-byte gap, abort and zero-length rejection.
module multi_byte_tx_seq #(
  parameter int MAX_BYTES  = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [MAX_BYTES*8-1:0] data_in,
  input  logic [LEN_W-1:0]       byte_len,
  input  logic                   abort,
  input  logic                   tx_done,
  output logic                   send_en,
  output logic [7:0]             data_byte,
  output logic [LEN_W-1:0]       byte_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   len_err
);

  localparam int W     = MAX_BYTES * 8;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]       state;
  logic [W-1:0]     shreg;
  logic [LEN_W-1:0] len_reg;
  logic [GAP_W-1:0] gap_cnt;
  logic             abort_pending;

  logic [LEN_W-1:0] len_eff;
  logic [W-1:0]     aligned;
  logic [W-1:0]     shifted;
  logic [7:0]       cur_byte;
  logic             last_byte;

  // MSB-first transfers left-justify the active field so the first byte always sits on top.
  always_comb begin
    len_eff = byte_len;
    if (byte_len > LEN_W'(MAX_BYTES)) len_eff = LEN_W'(MAX_BYTES);
    aligned = data_in;
    if (MSB_FIRST) aligned = data_in << {LEN_W'(MAX_BYTES) - len_eff, 3'b000};
    if (MSB_FIRST) begin
      cur_byte = shreg[W-1 -: 8];
      shifted  = shreg << 8;
    end else begin
      cur_byte = shreg[7:0];
      shifted  = shreg >> 8;
    end
    last_byte = (byte_idx == len_reg - LEN_W'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      shreg         <= '0;
      len_reg       <= '0;
      gap_cnt       <= '0;
      abort_pending <= 1'b0;
      send_en       <= 1'b0;
      data_byte     <= '0;
      byte_idx      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      send_en <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          abort_pending <= 1'b0;
          if (start) begin
            if (byte_len == '0) begin
              len_err <= 1'b1;
            end else begin
              shreg    <= aligned;
              len_reg  <= len_eff;
              byte_idx <= '0;
              busy     <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          data_byte <= cur_byte;
          shreg     <= shifted;
          send_en   <= 1'b1;
          state     <= WAIT;
          if (abort) abort_pending <= 1'b1;
        end
        WAIT: begin
          // A tx_done overlapping our own send_en belongs to no byte of ours.
          if (tx_done && !send_en) begin
            if (last_byte && !abort_pending) begin
              done          <= 1'b1;
              busy          <= 1'b0;
              abort_pending <= 1'b0;
              state         <= IDLE;
            end else if (abort_pending || abort) begin
              aborted       <= 1'b1;
              busy          <= 1'b0;
              abort_pending <= 1'b0;
              state         <= IDLE;
            end else begin
              byte_idx <= byte_idx + LEN_W'(1);
              gap_cnt  <= '0;
              if (GAP_CYCLES == 0) state <= ISSUE;
              else                 state <= GAP;
            end
          end else if (abort) begin
            abort_pending <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            aborted       <= 1'b1;
            busy          <= 1'b0;
            abort_pending <= 1'b0;
            state         <= IDLE;
          end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= ISSUE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_byte_tx_seq.sv
// Bench for multi_byte_tx_seq: three instances (MSB-first, LSB-first, MSB-first with gap 3)
// driven by directed and random transfers, each checked against a byte-list model.
module tb_multi_byte_tx_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] data_in = '0;
  logic [2:0]  byte_len = '0;
  logic        start_v   [3];
  logic        abort_v   [3];
  logic        tx_done_v [3];
  logic        send_en_v [3];
  logic [7:0]  data_byte_v [3];
  logic [2:0]  byte_idx_v  [3];
  logic        busy_v    [3];
  logic        done_v    [3];
  logic        aborted_v [3];
  logic        len_err_v [3];

  int msb [3] = '{1, 0, 1};
  int gap [3] = '{0, 0, 3};

  int total = 0;
  int bad = 0;
  int ab_kind = 0;  // 0 none, 1 abort mid-wait, 2 abort with tx_done, 3 abort in gap, 4 reset mid-wait
  int ab_byte = 0;
  bit early_done = 1'b0;
  bit restart_busy = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    multi_byte_tx_seq #(
      .MAX_BYTES (4),
      .MSB_FIRST (gi != 1),
      .GAP_CYCLES((gi == 2) ? 3 : 0)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start_v[gi]),
      .data_in  (data_in),
      .byte_len (byte_len),
      .abort    (abort_v[gi]),
      .tx_done  (tx_done_v[gi]),
      .send_en  (send_en_v[gi]),
      .data_byte(data_byte_v[gi]),
      .byte_idx (byte_idx_v[gi]),
      .busy     (busy_v[gi]),
      .done     (done_v[gi]),
      .aborted  (aborted_v[gi]),
      .len_err  (len_err_v[gi])
    );
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs(input int u);
    return {send_en_v[u], data_byte_v[u], byte_idx_v[u], busy_v[u], done_v[u],
            aborted_v[u], len_err_v[u]};
  endfunction

  // One transfer on instance u; the UART answers tx_done dly clocks after each send_en.
  task automatic xfer(input int u, input logic [31:0] d, input int len, input int dly);
    logic [7:0] exp_q[$];
    int n;
    int cnt;
    bit last;
    bit ab_now;
    n = (len > 4) ? 4 : len;
    for (int i = 0; i < n; i++)
      exp_q.push_back((msb[u] != 0) ? d[8*(n-1-i) +: 8] : d[8*i +: 8]);
    $display("xfer inst=%0d data=%08h len=%0d dly=%0d kind=%0d", u, d, len, dly, ab_kind);
    data_in = d;
    byte_len = 3'(len);
    start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    if (n == 0) begin
      chk1("len_err_pulse", len_err_v[u], 1'b1);
      chk1("len_err_busy", busy_v[u], 1'b0);
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (c == 0) chk1("len_err_one_cycle", len_err_v[u], 1'b0);
        chk1("len_err_no_send", send_en_v[u], 1'b0);
        chk1("len_err_idle", busy_v[u], 1'b0);
      end
      return;
    end
    chk1("busy_after_start", busy_v[u], 1'b1);
    chk1("no_send_yet", send_en_v[u], 1'b0);
    chk1("done_one_cycle", done_v[u], 1'b0);
    chk1("aborted_one_cycle", aborted_v[u], 1'b0);
    @(posedge clk); #1;
    chk1("first_send_latency", send_en_v[u], 1'b1);
    for (int j = 0; j < n; j++) begin
      last = (j == n - 1);
      chk1("send_en_high", send_en_v[u], 1'b1);
      chkv("data_byte", 32'(data_byte_v[u]), 32'(exp_q[j]));
      chkv("byte_idx", 32'(byte_idx_v[u]), 32'(j));
      if (early_done && j == 0) tx_done_v[u] = 1'b1;
      if (restart_busy && j == 0) begin
        data_in = ~d;
        byte_len = 3'd1;
        start_v[u] = 1'b1;
      end
      @(posedge clk); #1;
      tx_done_v[u] = 1'b0;
      start_v[u] = 1'b0;
      chkv("byte_idx_not_double", 32'(byte_idx_v[u]), 32'(j));
      for (int c = 1; c < dly; c++) begin
        chk1("send_en_one_cycle", send_en_v[u], 1'b0);
        chkv("data_byte_hold", 32'(data_byte_v[u]), 32'(exp_q[j]));
        if (ab_kind == 4 && ab_byte == j && c == 4) begin
          rstn = 1'b0;
          #1;
          chkv("reset_async_clear", 32'(outs(u)), 32'd0);
          @(posedge clk); #1;
          chkv("reset_held", 32'(outs(u)), 32'd0);
          rstn = 1'b1;
          return;
        end
        abort_v[u] = (ab_kind == 1 && ab_byte == j && c == 3) ||
                     (ab_kind == 2 && ab_byte == j && c == dly - 1);
        tx_done_v[u] = (c == dly - 1);
        @(posedge clk); #1;
      end
      tx_done_v[u] = 1'b0;
      abort_v[u] = 1'b0;
      if (last) begin
        chk1("done_pulse", done_v[u], 1'b1);
        chk1("done_not_aborted", aborted_v[u], 1'b0);
        chk1("busy_low_with_done", busy_v[u], 1'b0);
        return;
      end
      chk1("no_early_done", done_v[u], 1'b0);
      ab_now = (ab_kind == 1 || ab_kind == 2) && ab_byte == j;
      if (ab_kind == 3 && ab_byte == j) begin
        abort_v[u] = 1'b1;
        @(posedge clk); #1;
        abort_v[u] = 1'b0;
        ab_now = 1'b1;
      end
      if (ab_now) begin
        chk1("abort_pulse", aborted_v[u], 1'b1);
        chk1("abort_no_done", done_v[u], 1'b0);
        chk1("abort_busy_low", busy_v[u], 1'b0);
        for (int c = 0; c < 6; c++) begin
          @(posedge clk); #1;
          if (c == 0) chk1("abort_one_cycle", aborted_v[u], 1'b0);
          chk1("abort_no_send", send_en_v[u], 1'b0);
          chk1("abort_never_done", done_v[u], 1'b0);
        end
        return;
      end
      cnt = 0;
      while (send_en_v[u] !== 1'b1 && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      chkv("issue_spacing", 32'(cnt), 32'(gap[u] + 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      tx_done_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chkv("reset_state", 32'(outs(i)), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    xfer(0, 32'hA1B2C3D4, 4, 10);
    xfer(0, 32'hA1B2C3D4, 2, 10);
    xfer(1, 32'hA1B2C3D4, 4, 10);
    xfer(0, 32'hA1B2C3D4, 7, 10);
    xfer(2, 32'hA1B2C3D4, 3, 10);

    ab_kind = 1; ab_byte = 1;
    xfer(0, 32'h11223344, 4, 10);
    ab_kind = 3; ab_byte = 0;
    xfer(2, 32'h55667788, 4, 6);
    ab_kind = 2; ab_byte = 3;
    xfer(0, 32'h99AABBCC, 4, 5);
    ab_kind = 0;

    xfer(0, 32'hDEADBEEF, 0, 5);
    restart_busy = 1'b1;
    xfer(0, 32'hCAFEF00D, 3, 8);
    restart_busy = 1'b0;

    ab_kind = 4; ab_byte = 2;
    xfer(0, 32'h01020304, 4, 10);
    ab_kind = 0;
    early_done = 1'b1;
    xfer(0, 32'h5A6B7C8D, 4, 6);
    early_done = 1'b0;

    for (int k = 0; k < 25; k++) begin
      early_done = ($urandom_range(3, 0) == 0);
      xfer(int'($urandom_range(2, 0)), $urandom, int'($urandom_range(7, 0)),
           int'($urandom_range(12, 2)));
    end
    early_done = 1'b0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
